// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive frame buffer controller.
package eth_pkg;

    // Default depth (log2, in 32-bit words); this is also the width of the
    // header length field, since a frame can never hold more words than that.
    localparam int HDR_LEN_W   = 11;
    // Bit offset of the length field inside the header word.
    localparam int HDR_LEN_LSB = 0;
    // Largest accepted frame, in data words.
    localparam int ETH_MAX_WORDS = 384;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_HDR  = 2'd2,
        WR_DROP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_HDR_RD   = 2'd1,
        RD_HDR_WAIT = 2'd2,
        RD_DATA     = 2'd3
    } rd_state_t;

endpackage

// File: rtl/eth_frame_bram.sv
// Simple dual-port frame RAM: one write port, one read port with a
// registered read (data appears the cycle after i_re). No reset.
module eth_frame_bram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [1 << ADDR_W];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/eth_rx_frame_buf_ctrl.sv
// Receive frame buffer: MAC words go into a circular RAM behind a length
// header; committed frames are replayed to the consumer as a valid/ready
// stream with sof/eof markers.
module eth_rx_frame_buf_ctrl
    import eth_pkg::*;
#(
    parameter int ADDR_W    = HDR_LEN_W,
    parameter int MAX_WORDS = ETH_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_in,
    input  logic              wr_chk_in,
    input  logic              wr_clr_in,
    input  logic [35:0]       wr_d_in,
    output logic              wr_full_out,
    output logic              rd_valid_out,
    input  logic              rd_ready_in,
    output logic [31:0]       rd_d_out,
    output logic              rd_sof_out,
    output logic              rd_eof_out,
    output logic [ADDR_W-1:0] rd_len_out,
    output logic [15:0]       frames_ok_out,
    output logic [15:0]       frames_drop_out
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  DEPTH_M1 = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  FULL_TH = PTR_W'(DEPTH - 2);
    localparam logic [PTR_W-1:0]  ONE_P = PTR_W'(1);
    localparam logic [PTR_W-1:0]  TWO_P = PTR_W'(2);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
    localparam logic [15:0]       MAX_CNT = 16'(MAX_WORDS);

    // ---------------- write side ----------------
    wr_state_t          r_wr_state, w_wr_state_next;
    logic [PTR_W-1:0]   r_wr_ptr, r_hdr_ptr, r_commit_ptr, r_rel_ptr;
    logic [PTR_W-1:0]   w_wr_ptr_next, w_hdr_ptr_next, w_commit_ptr_next;
    logic [PTR_W-1:0]   w_used;
    logic [15:0]        r_cnt, w_cnt_next, r_ok, r_drop;
    logic               w_ok_inc, w_drop_inc;
    logic               w_room1, w_room2, w_too_long;
    logic [ADDR_W-1:0]  w_hdr_p1;
    logic               w_ram_we;
    logic [ADDR_W-1:0]  w_ram_waddr;
    logic [31:0]        w_ram_wdata;
    logic               w_unused_tag;

    // The four tag bits from the MAC carry nothing this block needs.
    assign w_unused_tag = ^wr_d_in[35:32];

    assign w_used     = r_wr_ptr - r_rel_ptr;
    // A data word needs one free slot; the first word of a frame also needs
    // its header slot. Exact fit (header + data == DEPTH) is accepted.
    assign w_room1    = (w_used < DEPTH_P);
    assign w_room2    = (w_used < DEPTH_M1);
    assign w_too_long = (r_cnt >= MAX_CNT);
    assign w_hdr_p1   = r_hdr_ptr[ADDR_W-1:0] + ONE_A;

    assign wr_full_out     = rst | (w_used > FULL_TH) | (r_wr_state == WR_HDR);
    assign frames_ok_out   = r_ok;
    assign frames_drop_out = r_drop;

    // Write FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wr_state <= WR_IDLE;
        else     r_wr_state <= w_wr_state_next;
    end

    // Write FSM next-state logic
    always_comb begin
        w_wr_state_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (wr_en_in && !wr_clr_in) begin
                if (!w_room2) w_wr_state_next = wr_chk_in ? WR_IDLE : WR_DROP;
                else          w_wr_state_next = wr_chk_in ? WR_HDR  : WR_DATA;
            end
            WR_DATA: if (wr_en_in) begin
                if (wr_clr_in)                   w_wr_state_next = WR_IDLE;
                else if (!w_room1 || w_too_long) w_wr_state_next = wr_chk_in ? WR_IDLE : WR_DROP;
                else if (wr_chk_in)              w_wr_state_next = WR_HDR;
            end
            WR_HDR:  w_wr_state_next = WR_IDLE;
            WR_DROP: if (wr_en_in && (wr_chk_in || wr_clr_in)) w_wr_state_next = WR_IDLE;
            default: w_wr_state_next = WR_IDLE;
        endcase
    end

    // Write FSM outputs: RAM write port, pointer updates, frame counters.
    // An overflowing word that also ends the frame is counted right away so
    // each frame contributes exactly one drop.
    always_comb begin
        w_ram_we          = 1'b0;
        w_ram_waddr       = r_wr_ptr[ADDR_W-1:0];
        w_ram_wdata       = wr_d_in[31:0];
        w_wr_ptr_next     = r_wr_ptr;
        w_hdr_ptr_next    = r_hdr_ptr;
        w_commit_ptr_next = r_commit_ptr;
        w_cnt_next        = r_cnt;
        w_ok_inc          = 1'b0;
        w_drop_inc        = 1'b0;
        case (r_wr_state)
            WR_IDLE: if (wr_en_in) begin
                if (wr_clr_in) begin
                    w_drop_inc = 1'b1;
                end else if (!w_room2) begin
                    w_drop_inc = wr_chk_in;
                end else begin
                    w_ram_we      = 1'b1;
                    w_ram_waddr   = w_hdr_p1;
                    w_wr_ptr_next = r_hdr_ptr + TWO_P;
                    w_cnt_next    = 16'd1;
                end
            end
            WR_DATA: if (wr_en_in) begin
                if (wr_clr_in) begin
                    w_wr_ptr_next = r_hdr_ptr;
                    w_drop_inc    = 1'b1;
                end else if (!w_room1 || w_too_long) begin
                    w_wr_ptr_next = r_hdr_ptr;
                    w_drop_inc    = wr_chk_in;
                end else begin
                    w_ram_we      = 1'b1;
                    w_wr_ptr_next = r_wr_ptr + ONE_P;
                    w_cnt_next    = r_cnt + 16'd1;
                end
            end
            WR_HDR: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_hdr_ptr[ADDR_W-1:0];
                w_ram_wdata = '0;
                w_ram_wdata[HDR_LEN_LSB +: ADDR_W] = r_cnt[ADDR_W-1:0];
                w_commit_ptr_next = r_wr_ptr;
                w_hdr_ptr_next    = r_wr_ptr;
                w_ok_inc          = 1'b1;
                w_drop_inc        = wr_en_in;
            end
            WR_DROP: w_drop_inc = wr_en_in & (wr_chk_in | wr_clr_in);
            default: ;
        endcase
    end

    // Write-side datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_hdr_ptr    <= '0;
            r_commit_ptr <= '0;
            r_cnt        <= '0;
            r_ok         <= '0;
            r_drop       <= '0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_next;
            r_hdr_ptr    <= w_hdr_ptr_next;
            r_commit_ptr <= w_commit_ptr_next;
            r_cnt        <= w_cnt_next;
            if (w_ok_inc)   r_ok   <= r_ok + 16'd1;
            if (w_drop_inc) r_drop <= r_drop + 16'd1;
        end
    end

    // ---------------- read side ----------------
    rd_state_t          r_rd_state, w_rd_state_next;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]  r_len, r_fetch_left, r_beat;
    logic               r_pend, r_out_v, r_skid_v;
    logic [31:0]        r_out_d, r_skid_d, w_ram_rdata;
    logic               w_pop, w_last_beat, w_issue, w_ram_re;
    logic [1:0]         w_occ;
    logic [ADDR_W-1:0]  w_ram_raddr;

    assign w_pop       = r_out_v & rd_ready_in;
    assign w_last_beat = (r_beat == r_len - ONE_A);
    // Words in flight or held; the output register plus skid hold two.
    assign w_occ       = {1'b0, r_out_v} + {1'b0, r_skid_v} + {1'b0, r_pend};

    assign rd_valid_out = r_out_v;
    assign rd_d_out     = r_out_d;
    assign rd_sof_out   = r_out_v & (r_beat == '0);
    assign rd_eof_out   = r_out_v & w_last_beat;
    assign rd_len_out   = r_len;

    // Read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_state <= RD_IDLE;
        else     r_rd_state <= w_rd_state_next;
    end

    // Read FSM next-state logic; only committed frames are ever entered
    always_comb begin
        w_rd_state_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE:     if (r_rd_ptr != r_commit_ptr) w_rd_state_next = RD_HDR_RD;
            RD_HDR_RD:   w_rd_state_next = RD_HDR_WAIT;
            RD_HDR_WAIT: w_rd_state_next = RD_DATA;
            RD_DATA:     if (w_pop && w_last_beat) w_rd_state_next = RD_IDLE;
            default:     w_rd_state_next = RD_IDLE;
        endcase
    end

    // Read FSM outputs: header read, then data prefetch while there is room
    always_comb begin
        w_ram_re    = 1'b0;
        w_issue     = 1'b0;
        w_ram_raddr = r_rd_ptr[ADDR_W-1:0];
        case (r_rd_state)
            RD_HDR_RD: w_ram_re = 1'b1;
            RD_DATA: if ((r_fetch_left != '0) && ((w_occ < 2'd2) || w_pop)) begin
                w_ram_re = 1'b1;
                w_issue  = 1'b1;
            end
            default: ;
        endcase
    end

    // Read-side datapath: pointers, beat count, output register and skid.
    // Arriving words always go behind anything already held, so order is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_rel_ptr    <= '0;
            r_len        <= '0;
            r_fetch_left <= '0;
            r_beat       <= '0;
            r_pend       <= 1'b0;
            r_out_v      <= 1'b0;
            r_out_d      <= '0;
            r_skid_v     <= 1'b0;
            r_skid_d     <= '0;
        end else begin
            r_pend <= w_issue;
            if (r_rd_state == RD_HDR_WAIT) begin
                r_len        <= w_ram_rdata[HDR_LEN_LSB +: ADDR_W];
                r_fetch_left <= w_ram_rdata[HDR_LEN_LSB +: ADDR_W];
                r_rd_ptr     <= r_rd_ptr + ONE_P;
                r_beat       <= '0;
            end else begin
                if (w_issue) begin
                    r_rd_ptr     <= r_rd_ptr + ONE_P;
                    r_fetch_left <= r_fetch_left - ONE_A;
                end
                if (w_pop) r_beat <= r_beat + ONE_A;
            end
            if (!r_out_v || w_pop) begin
                if (r_skid_v) begin
                    r_out_v  <= 1'b1;
                    r_out_d  <= r_skid_d;
                    r_skid_v <= r_pend;
                    r_skid_d <= w_ram_rdata;
                end else begin
                    r_out_v  <= r_pend;
                    r_out_d  <= w_ram_rdata;
                end
            end else if (r_pend) begin
                r_skid_v <= 1'b1;
                r_skid_d <= w_ram_rdata;
            end
            if (w_pop && w_last_beat) r_rel_ptr <= r_rd_ptr;
        end
    end

    eth_frame_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_bram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_eth_rx_frame_buf_ctrl.sv
// Scoreboard bench for eth_rx_frame_buf_ctrl on a 16-word buffer.
module tb_eth_rx_frame_buf_ctrl;

    localparam int AW = 4;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en_in, wr_chk_in, wr_clr_in;
    logic [35:0]   wr_d_in;
    logic          wr_full_out, rd_valid_out, rd_ready_in;
    logic [31:0]   rd_d_out;
    logic          rd_sof_out, rd_eof_out;
    logic [AW-1:0] rd_len_out;
    logic [15:0]   frames_ok_out, frames_drop_out;

    always #5 clk = ~clk;

    eth_rx_frame_buf_ctrl #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en_in        (wr_en_in),
        .wr_chk_in       (wr_chk_in),
        .wr_clr_in       (wr_clr_in),
        .wr_d_in         (wr_d_in),
        .wr_full_out     (wr_full_out),
        .rd_valid_out    (rd_valid_out),
        .rd_ready_in     (rd_ready_in),
        .rd_d_out        (rd_d_out),
        .rd_sof_out      (rd_sof_out),
        .rd_eof_out      (rd_eof_out),
        .rd_len_out      (rd_len_out),
        .frames_ok_out   (frames_ok_out),
        .frames_drop_out (frames_drop_out)
    );

    typedef struct packed {
        logic [31:0]   d;
        logic          sof;
        logic          eof;
        logic [AW-1:0] len;
    } beat_t;

    beat_t exp_q[$];
    int n_cmp = 0, n_bad = 0;
    int exp_ok = 0, exp_drop = 0;
    int gaps = 0;
    int rdy_mode = 1;   // 0: ready held 1, 1: ready held 0, 2: pattern 1,0,0,1

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Ready driver
    initial begin
        int k = 0;
        rd_ready_in = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: rd_ready_in = 1'b1;
                1: rd_ready_in = 1'b0;
                default: begin
                    rd_ready_in = ((k % 4) == 0) || ((k % 4) == 3);
                    k++;
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted beat
    initial begin
        beat_t e, a;
        bit in_frame = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 0;
            end else begin
                if (in_frame && rd_ready_in && !rd_valid_out) gaps++;
                if (rd_valid_out && rd_ready_in) begin
                    a.d = rd_d_out; a.sof = rd_sof_out; a.eof = rd_eof_out; a.len = rd_len_out;
                    if (exp_q.size() == 0) begin
                        chk("spurious_beat", 64'(rd_valid_out), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 64'(a), 64'(e));
                        in_frame = !e.eof;
                        $display("beat d=%08h sof=%0b eof=%0b len=%0d", a.d, a.sof, a.eof, a.len);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [31:0] d, input logic c, input logic x);
        wr_en_in = 1'b1; wr_chk_in = c; wr_clr_in = x; wr_d_in = {4'hA, d};
        @(posedge clk); #1;
        wr_en_in = 1'b0; wr_chk_in = 1'b0; wr_clr_in = 1'b0;
    endtask

    // n-word frame with chk on the last word; expected beats queued if it should commit
    task automatic send_frame(input int n, input logic [31:0] base, input logic [31:0] step, input bit good);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            if (good) begin
                b.d = base + step * 32'(i); b.sof = (i == 0); b.eof = (i == n - 1); b.len = AW'(n);
                exp_q.push_back(b);
            end
            send_word(base + step * 32'(i), (i == n - 1), 1'b0);
        end
        idle(1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin idle(1); t++; end
        chk({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
        idle(3);
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_ok"},   64'(frames_ok_out),   64'(16'(exp_ok)));
        chk({name, "_drop"}, 64'(frames_drop_out), 64'(16'(exp_drop)));
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en_in = 1'b0; wr_chk_in = 1'b0; wr_clr_in = 1'b0; wr_d_in = '0;
        idle(2);
        @(negedge clk);
        chk("rst_full", 64'(wr_full_out), 64'd1);
        chk("rst_valid", 64'(rd_valid_out), 64'd0);
        chk("rst_data", 64'(rd_d_out), 64'd0);
        chk("rst_len", 64'(rd_len_out), 64'd0);
        chk_cnt("rst");
        @(posedge clk); #1; rst = 1'b0;
        idle(1);
        chk("post_rst_full", 64'(wr_full_out), 64'd0);

        // 1: three-word frame, ready held
        rdy_mode = 0;
        send_frame(3, 32'h11111111, 32'h11111111, 1); exp_ok++;
        drain("t1"); chk_cnt("t1");

        // 2: frame discarded by clr, then a good two-word frame
        for (int i = 0; i < 4; i++) send_word(32'hBAD00000 + 32'(i), 1'b0, 1'b0);
        send_word(32'hBAD00004, 1'b0, 1'b1); exp_drop++;
        send_frame(2, 32'h22220000, 32'h1, 1); exp_ok++;
        drain("t2"); chk_cnt("t2");

        // 3: fill the buffer with reads stalled, third frame dropped
        rdy_mode = 1; idle(1);
        send_frame(7, 32'h33330000, 32'h1, 1); exp_ok++;
        idle(1);
        chk("t3_full_after_a", 64'(wr_full_out), 64'd0);
        send_frame(7, 32'h33340000, 32'h1, 1); exp_ok++;
        idle(1);
        chk("t3_full_after_b", 64'(wr_full_out), 64'd1);
        send_frame(3, 32'h33350000, 32'h1, 0); exp_drop++;
        chk_cnt("t3");
        rdy_mode = 0;
        drain("t3");
        chk("t3_full_drained", 64'(wr_full_out), 64'd0);

        // 4: ten-word frame with ready pattern 1,0,0,1
        rdy_mode = 2;
        send_frame(10, 32'h44440000, 32'h3, 1); exp_ok++;
        drain("t4"); chk_cnt("t4");
        rdy_mode = 0;

        // Boundaries: frame exactly filling the ring, then one word too long
        send_frame(15, 32'h55550000, 32'h1, 1); exp_ok++;
        drain("fit");
        send_frame(16, 32'h56560000, 32'h1, 0); exp_drop++;
        drain("long"); chk_cnt("long");

        // Word arriving during the header cycle is ignored and counted as a drop
        begin
            beat_t b;
            b.d = 32'hA5A5A5A5; b.sof = 1'b1; b.eof = 1'b1; b.len = AW'(1);
            exp_q.push_back(b);
            send_word(32'hA5A5A5A5, 1'b1, 1'b0); exp_ok++;
            send_word(32'hDEADBEEF, 1'b0, 1'b0); exp_drop++;
            idle(1);
        end
        drain("hdr_err"); chk_cnt("hdr_err");

        // 5: forty three-word frames, ten wraps of the 16-word ring
        for (int f = 0; f < 40; f++) begin
            int t = 0;
            while (exp_q.size() > 6 && t < 500) begin idle(1); t++; end
            if (exp_q.size() > 6) begin
                n_cmp++; n_bad++;
                $display("FAIL wrap_room_wait: queue %0d, required <= 6", exp_q.size());
            end
            send_frame(3, 32'h60000000 + 32'(f) * 32'h100, 32'h1, 1); exp_ok++;
        end
        drain("t5"); chk_cnt("t5");

        // 6: reset in mid-frame on both sides
        rdy_mode = 1; idle(1);
        send_frame(10, 32'h70000000, 32'h1, 1);
        for (int i = 0; i < 3; i++) send_word(32'h71000000 + 32'(i), 1'b0, 1'b0);
        idle(2);
        chk("t6_valid_before", 64'(rd_valid_out), 64'd1);
        rst = 1'b1;
        exp_q.delete(); exp_ok = 0; exp_drop = 0;
        #3;
        chk("t6_full_in_rst", 64'(wr_full_out), 64'd1);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("t6_valid_after", 64'(rd_valid_out), 64'd0);
        chk("t6_full_after", 64'(wr_full_out), 64'd0);
        chk_cnt("t6_cleared");
        @(posedge clk); #1;
        rdy_mode = 0;
        send_frame(4, 32'h80000000, 32'h10, 1); exp_ok++;
        drain("t6"); chk_cnt("t6");

        chk("gaps_while_ready", 64'(gaps), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
